// File: rtl/gf180_ram_pkg.sv
// Shared types and constants for the GF180 512x8 SRAM word sequencer.
package gf180_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic       CEN_IDLE       = 1'b0;
    localparam logic       GWEN_IDLE      = 1'b1;
    localparam logic [7:0] WEN_IDLE       = 8'hFF;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gf180_ram_word_seq.sv
// Serialises 32-bit native memory requests into four byte accesses on a GF180 512x8 SRAM.
//
// state | meaning
// IDLE  | waiting for mem_valid; RAM idle
// ACC   | byte k (0..3) presented to the RAM this cycle
// LAST  | reads only: RAM idle while byte 3 is captured
// DONE  | mem_ready pulse, then back to IDLE
module gf180_ram_word_seq
    import gf180_ram_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              ram_cen,
    output logic              ram_gwen,
    output logic [7:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam logic [1:0] K_LAST = 2'(BYTES_PER_WORD - 1);

    state_t            state, state_nxt;
    logic [1:0]        k, k_nxt;
    logic [ADDR_W-3:0] lat_word;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_wstrb;
    logic              lat_wr;
    logic [31:0]       shadow;
    logic              cap_en;
    logic [1:0]        cap_idx;

    logic              acc_go;
    logic [ADDR_W-3:0] acc_word;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_wstrb;
    logic              acc_wr;
    logic              cen_nxt, gwen_nxt;
    logic [7:0]        wen_nxt, wdata_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    // RAM pins are registered: this block computes what the next cycle presents.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        acc_go    = 1'b0;
        acc_word  = lat_word;
        acc_wdata = lat_wdata;
        acc_wstrb = lat_wstrb;
        acc_wr    = lat_wr;
        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    state_nxt = ST_ACC;
                    k_nxt     = 2'd0;
                    acc_go    = 1'b1;
                    acc_word  = mem_addr[ADDR_W-1:2];
                    acc_wdata = mem_wdata;
                    acc_wstrb = mem_wstrb;
                    acc_wr    = |mem_wstrb;
                end
            end
            ST_ACC: begin
                if (k == K_LAST) begin
                    state_nxt = lat_wr ? ST_DONE : ST_LAST;
                end else begin
                    k_nxt  = k + 2'd1;
                    acc_go = 1'b1;
                end
            end
            ST_LAST: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase

        cen_nxt   = CEN_IDLE;
        gwen_nxt  = GWEN_IDLE;
        wen_nxt   = WEN_IDLE;
        addr_nxt  = ram_addr;
        wdata_nxt = ram_wdata;
        if (acc_go) begin
            addr_nxt  = {acc_word, k_nxt};
            wdata_nxt = byte_of(acc_wdata, k_nxt);
            if (!acc_wr) begin
                cen_nxt = 1'b1;
            end else if (acc_wstrb[k_nxt]) begin
                cen_nxt  = 1'b1;
                gwen_nxt = 1'b0;
                wen_nxt  = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            k         <= 2'd0;
            lat_word  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_wr    <= 1'b0;
            shadow    <= '0;
            cap_en    <= 1'b0;
            cap_idx   <= 2'd0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            ram_cen   <= CEN_IDLE;
            ram_gwen  <= GWEN_IDLE;
            ram_wen   <= WEN_IDLE;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            ram_cen   <= cen_nxt;
            ram_gwen  <= gwen_nxt;
            ram_wen   <= wen_nxt;
            ram_addr  <= addr_nxt;
            ram_wdata <= wdata_nxt;
            mem_ready <= (state_nxt == ST_DONE);
            if (state == ST_IDLE && mem_valid) begin
                lat_word  <= mem_addr[ADDR_W-1:2];
                lat_wdata <= mem_wdata;
                lat_wstrb <= mem_wstrb;
                lat_wr    <= |mem_wstrb;
            end
            // Q for the byte read in ACC k is only valid in the following cycle.
            cap_en  <= (state == ST_ACC) && !lat_wr;
            cap_idx <= k;
            if (cap_en) begin
                shadow[{cap_idx, 3'b000} +: 8] <= ram_rdata;
            end
            if (state == ST_LAST) begin
                mem_rdata <= {ram_rdata, shadow[23:0]};
            end
        end
    end

endmodule

// File: tb/tb_gf180_ram_word_seq.sv
// Self-checking bench for gf180_ram_word_seq with a behavioural SRAM and word-level reference model.
module tb_gf180_ram_word_seq;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              resetn;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              ram_cen;
    logic              ram_gwen;
    logic [7:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    gf180_ram_word_seq #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .ram_cen   (ram_cen),
        .ram_gwen  (ram_gwen),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: Q valid only in the cycle after a read edge; garbage stands in for X otherwise.
    logic [7:0] sram [DEPTH];
    logic [7:0] q, junk;
    logic       q_vld;
    always @(posedge clk) begin
        junk  <= 8'($urandom);
        q_vld <= 1'b0;
        if (ram_cen) begin
            if (!ram_gwen) begin
                sram[ram_addr] <= (sram[ram_addr] & ram_wen) | (ram_wdata & ~ram_wen);
            end else begin
                q     <= sram[ram_addr];
                q_vld <= 1'b1;
            end
        end
    end
    assign ram_rdata = q_vld ? q : junk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] last_rd;

    typedef struct {
        int         cyc;
        logic [8:0] a;
        logic [7:0] d;
        logic       gwen;
        logic [7:0] wen;
    } acc_t;
    acc_t trace[$];

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ready"}, 32'(mem_ready), 32'd0);
        chk({name, "_rdata"}, mem_rdata, 32'd0);
        chk({name, "_cen"},   32'(ram_cen), 32'd0);
        chk({name, "_gwen"},  32'(ram_gwen), 32'd1);
        chk({name, "_wen"},   32'(ram_wen), 32'hFF);
        chk({name, "_addr"},  32'(ram_addr), 32'd0);
        chk({name, "_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    // One request; mem_valid drops right after E0. lat = cycle (after E0) with mem_ready.
    task automatic run_req(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [31:0] rd);
        bit saw_x;
        lat   = -1;
        rd    = 'x;
        saw_x = 1'b0;
        trace.delete();
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        @(posedge clk);
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mem_valid = 1'b0;
                mem_wdata = 32'($urandom);
                mem_addr  = 9'($urandom);
                mem_wstrb = 4'($urandom);
            end
            if ($isunknown(mem_rdata)) saw_x = 1'b1;
            if (ram_cen) trace.push_back('{c, ram_addr, ram_wdata, ram_gwen, ram_wen});
            if (mem_ready) begin
                lat = c;
                rd  = mem_rdata;
            end
        end
        chk("rdata_known", 32'(saw_x), 32'd0);
        @(negedge clk);
        chk("ready_one_cycle", 32'(mem_ready), 32'd0);
    endtask

    task automatic check_trace(input string name, input logic [8:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        acc_t exp_q[$];
        logic [31:0] dw;
        dw = d;
        for (int i = 0; i < 4; i++) begin
            if (s == 4'd0 || s[i]) begin
                exp_q.push_back('{i + 1, {a[8:2], 2'(i)}, dw[8*i +: 8], (s == 4'd0),
                                  (s == 4'd0) ? 8'hFF : 8'h00});
            end
        end
        chk({name, "_n_acc"}, 32'(trace.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < trace.size(); j++) begin
            chk({name, "_cyc"},  32'(trace[j].cyc), 32'(exp_q[j].cyc));
            chk({name, "_addr"}, 32'(trace[j].a),   32'(exp_q[j].a));
            chk({name, "_gwen"}, 32'(trace[j].gwen), 32'(exp_q[j].gwen));
            chk({name, "_wen"},  32'(trace[j].wen), 32'(exp_q[j].wen));
            if (s != 4'd0) chk({name, "_wbyte"}, 32'(trace[j].d), 32'(exp_q[j].d));
        end
    endtask

    function automatic logic [31:0] model_word(input logic [8:0] a);
        int b;
        b = {a[8:2], 2'b00};
        return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    endfunction

    function automatic void model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        int b;
        b = {a[8:2], 2'b00};
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[b + i] = d[8*i +: 8];
    endfunction

    task automatic transact(input string name, input logic [8:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] exp_rd);
        int          lat;
        logic [31:0] rd;
        run_req(a, d, s, lat, rd);
        chk({name, "_latency"}, 32'(lat), (s == 4'd0) ? 32'd6 : 32'd5);
        chk({name, "_rdata"}, rd, exp_rd);
        check_trace(name, a, d, s);
        if (s == 4'd0) last_rd = exp_rd;
        else model_write(a, d, s);
    endtask

    initial begin
        int          first, second, pulses;
        logic [8:0]  ra;
        logic [31:0] rdat;
        logic [3:0]  rs;

        vecs[0] = '{9'h010, 32'hDEADBEEF, 4'hF,    32'h00000000};
        vecs[1] = '{9'h010, 32'h00000000, 4'h0,    32'hDEADBEEF};
        vecs[2] = '{9'h1FC, 32'h11223344, 4'hF,    32'hDEADBEEF};
        vecs[3] = '{9'h1FC, 32'hAABBCCDD, 4'b0101, 32'hDEADBEEF};
        vecs[4] = '{9'h1FC, 32'h00000000, 4'h0,    32'h11BB33DD};
        vecs[5] = '{9'h013, 32'h00000000, 4'h0,    32'hDEADBEEF};
        vecs[6] = '{9'h020, 32'hCAFEF00D, 4'b1000, 32'hDEADBEEF};
        vecs[7] = '{9'h021, 32'h00000000, 4'h0,    32'hCA000000};

        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        last_rd   = 32'd0;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            transact($sformatf("vec%0d", i), vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].exp);
        end

        // mem_valid held across two reads: second accepted in the IDLE cycle after DONE.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 9'h010;
        mem_wstrb = 4'h0;
        @(posedge clk);
        first  = -1;
        second = -1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                pulses++;
                chk("b2b_rdata", mem_rdata, 32'hDEADBEEF);
                if (first < 0) first = c;
                else begin
                    second    = c;
                    mem_valid = 1'b0;
                end
            end
        end
        mem_valid = 1'b0;
        chk("b2b_first", 32'(first), 32'd6);
        chk("b2b_second", 32'(second), 32'd13);
        chk("b2b_pulses", 32'(pulses), 32'd2);
        last_rd = 32'hDEADBEEF;

        // Reset during ACC k=1: byte 0 already written, the rest aborted.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 9'h100;
        mem_wdata = 32'h55667788;
        mem_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_cen", 32'(ram_cen), 32'd0);
        chk("post_reset_ready", 32'(mem_ready), 32'd0);
        ref_mem[9'h100] = 8'h88;
        last_rd = 32'd0;
        transact("partial_commit", 9'h100, 32'd0, 4'h0, 32'h00000088);

        for (int i = 0; i < 40; i++) begin
            ra   = 9'($urandom_range(0, DEPTH - 1));
            rdat = $urandom;
            rs   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            transact($sformatf("rand%0d", i), ra, rdat, rs, (rs == 4'h0) ? model_word(ra) : last_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gf180_ram_word_seq.md
# gf180_ram_word_seq

Word-to-byte access sequencer that sits directly upstream of the GF180 512x8 SRAM macro wrapper. It accepts 32-bit PicoRV32-style native memory requests (valid/ready, byte strobes) and serialises each one into four byte-wide SRAM accesses. Read bytes are reassembled into a little-endian word. Each SRAM instance in the SoC memory map gets one sequencer.

## Interface
Parameters:
- ADDR_W, 9, SRAM byte-address width; SRAM depth is 2^ADDR_W bytes. Must be ≥ 3.

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  request strobe, already qualified by SoC address decode
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  ADDR_W  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 4'b0000 = read
- mem_rdata  out  32  read data, valid while mem_ready=1 and held afterwards
- ram_cen  out  1  SRAM chip enable, active high
- ram_gwen  out  1  SRAM global write enable, active low
- ram_wen  out  8  SRAM bit write enables, active low
- ram_addr  out  ADDR_W  SRAM byte address
- ram_wdata  out  8  SRAM write byte
- ram_rdata  in  8  SRAM read byte (Q), valid the cycle after the read edge

## Operation
- States: IDLE, ACC (2-bit byte index k = 0..3), LAST, DONE.
- IDLE: when mem_valid=1, latch addr, wdata, wstrb and the read/write flag. Go to ACC with k=0.
- ACC k: RAM outputs are registered and present byte k for this whole cycle.
  - ram_addr = {addr[ADDR_W-1:2], k}
  - ram_wdata = wdata[8k+7:8k]
  - Read: cen=1, gwen=1, wen=8'hFF.
  - Write with wstrb[k]=1: cen=1, gwen=0, wen=8'h00.
  - Write with wstrb[k]=0: cen=0, gwen=1, wen=8'hFF. The byte slot is still spent, so the cycle count is fixed.
  - k increments each cycle. After k=3, reads go to LAST and writes go to DONE.
- Read capture: ram_rdata is sampled into byte k of a shadow register on the edge ending the cycle after ACC k. For k=3 that is the edge ending LAST.
- LAST (reads only): RAM idle (cen=0); byte 3 is captured.
- DONE: mem_ready=1 for exactly one cycle. For reads, mem_rdata is updated from the shadow register on entry. Then return to IDLE unconditionally.
- When not accessing, RAM outputs are idle: cen=0, gwen=1, wen=8'hFF. ram_addr and ram_wdata hold their last value.
- mem_valid is ignored outside IDLE. Deasserting it mid-transaction does not abort; the access completes and mem_ready still pulses.
- If mem_valid is still high in the IDLE cycle after DONE, it is taken as a new request (back-to-back).
- Writes never modify mem_rdata.
- Reset mid-transaction aborts immediately. A write may be partially committed, which is acceptable.

## Timing
- Reset values (asynchronous): state=IDLE, mem_ready=0, mem_rdata=0, ram_cen=0, ram_gwen=1, ram_wen=8'hFF, ram_addr=0, ram_wdata=0.
- Count from edge E0 = the edge sampling mem_valid in IDLE.
- Read: ACC during cycles after E0..E3, LAST after E4, mem_ready high after E5.
  - Latency: mem_ready in the 6th cycle after E0.
- Write: ACC during cycles after E0..E3, mem_ready high after E4.
  - Latency: 5th cycle after E0.
- Sustained throughput:
  - reads: one word per 7 cycles
  - writes: one word per 6 cycles
- No combinational path from any input to any output.

## Structure
- Shared package gf180_ram_pkg holds:
  - the state enum
  - BYTES_PER_WORD = 4
  - RAM idle constants: CEN_IDLE = 0, GWEN_IDLE = 1, WEN_IDLE = 8'hFF
- Single module with no sub-modules. The gf180_ram_512x8x1 macro wrapper is instantiated beside this block at SoC level, with ram_* wired port-to-port.

## Test plan
- Reset: assert resetn=0 mid-ACC → all outputs at reset values within the same cycle. After release, state is IDLE and cen=0.
- Full write then read: write 0xDEADBEEF to addr 0x010 with wstrb=4'hF → four cen=1/gwen=0 cycles at ram_addr 0x010..0x013 with ram_wdata EF, BE, AD, DE; mem_ready in cycle 5. Then read 0x010 → mem_ready in cycle 6 with mem_rdata=0xDEADBEEF.
- Partial write: preload 0x11223344 at addr 0x1FC, then write 0xAABBCCDD with wstrb=4'b0101 → cen=1 only at k=0 and k=2. Read-back returns 0x11BB33DD.
- Low address bits: read from addr 0x013 → ram_addr sequence 0x010..0x013, same data as a read of 0x010.
- Back-to-back with mid-transaction drop: hold mem_valid high across two reads → second request accepted in the IDLE cycle after DONE, exactly one mem_ready per request. Separately, drop mem_valid after E0 → transaction still completes with mem_ready.
- RAM model: bench SRAM model returns Q one cycle after the read edge. Inject X on ram_rdata in all other cycles → mem_rdata is never X.
